rom_pixel_streamer: RTL
=======================

// Module: rom_pixel_streamer
// PURPOSE
//  Downstream consumer of the ROM read stage: walks a WIDTH x HEIGHT image stored row-major in ROM,
//  issues one address per cycle, absorbs the fixed ROM read latency and emits (x, y, colour) pixels
//  on a valid/ready stream to the LCD writer. Frame starts on start; busy/done report progress.
//  Output buffering guarantees no pixel loss under arbitrary pixel_ready backpressure.
// PARAMETERS
//  WIDTH        16      image width in pixels (>=1)
//  HEIGHT       16      image height in pixels (>=1)
//  ADDR_WIDTH   8       ROM address width; must hold BASE_ADDR+WIDTH*HEIGHT-1
//  DATA_WIDTH   16      ROM word / pixel colour width (RGB565)
//  BASE_ADDR    0       ROM address of pixel (0,0)
//  ROM_LATENCY  2       cycles from rom_addr change to matching rom_data (>=1)
//  TRANSPARENT  16'hF81F  colour skipped when STREAMER_TRANSPARENCY_EN defined
// PORTS
//  clock        in   1              system clock, rising edge
//  reset        in   1              asynchronous, active-high
//  start        in   1              begin frame; sampled only in IDLE
//  busy         out  1              high from start accept until done
//  done         out  1              one-cycle pulse after last pixel handshake
//  rom_addr     out  ADDR_WIDTH     ROM read address
//  rom_data     in   DATA_WIDTH     ROM word, valid ROM_LATENCY cycles after rom_addr
//  pixel_x      out  clog2(WIDTH)   column of pixel_data
//  pixel_y      out  clog2(HEIGHT)  row of pixel_data
//  pixel_data   out  DATA_WIDTH     colour
//  pixel_valid  out  1              pixel_* valid
//  pixel_ready  in   1              consumer accepts when valid&&ready at clock edge
// BEHAVIOUR
//  Reset: busy=0, done=0, rom_addr=BASE_ADDR, pixel_valid=0, pixel_x/y/data=0, FIFO empty,
//   latency valid-pipe cleared (in-flight ROM words discarded). Applies immediately, mid-frame included.
//  FSM: IDLE -start-> RUN; RUN -last address issued-> DRAIN; DRAIN -FIFO empty & pipe empty-> DONE;
//   DONE -> IDLE unconditionally (done=1 for exactly this cycle). start outside IDLE ignored.
//  RUN: rom_addr=BASE_ADDR+y*WIDTH+x; x increments, wraps to 0 at WIDTH-1 with y++. Address advances
//   only when credit available: fifo_count + in_flight < FIFO_DEPTH, FIFO_DEPTH = ROM_LATENCY+2.
//  Shift-register valid pipe of ROM_LATENCY stages carries {x,y} alongside each issued address;
//   at pipe exit rom_data and {x,y} are pushed into the FIFO. Credit rule makes overflow impossible.
//  Output: FIFO head drives pixel_*; pop on valid&&ready. Simultaneous push and pop on full/empty FIFO
//   is legal; empty FIFO with push presents data next cycle (no combinational bypass).
//  Throughput: 1 pixel/cycle with pixel_ready held high; first pixel_valid ROM_LATENCY+2 cycles after
//   the start edge. Order strictly row-major; no duplication, no loss.
//  Arithmetic: address computed incrementally (running counter), no multiplier; counters unsigned,
//   widths from clog2; WIDTH or HEIGHT of 1 wraps immediately.
// CONFIGURATION
//  STREAMER_TRANSPARENCY_EN defined: words equal to TRANSPARENT are not pushed into the FIFO (credit
//   released), so those pixels never appear; done still pulses after the final non-skipped pixel or,
//   if all skipped, once the pipe drains. Undefined: every word is emitted, TRANSPARENT unused.
// STRUCTURE
//  Package rom_stream_pkg: FSM state encodings (IDLE, RUN, DRAIN, DONE), clog2 function,
//   FIFO_DEPTH derivation constant.
//  Sub-module stream_fifo (synchronous FIFO, parameter DEPTH, WIDTH) holds {x,y,colour};
//   top level holds FSM, counters, credit logic, latency pipe.
// TESTING
//  1 WIDTH=4,HEIGHT=2,BASE_ADDR=0, ROM model word=addr+16'h0100, ready=1, pulse start -> 8 pixels
//    0x0100..0x0107, (x,y)=(0,0)..(3,1), back-to-back, first valid 4 cycles after start, done 1 cycle.
//  2 Same frame, pixel_ready toggling 1/0 each cycle -> identical 8-pixel sequence, no FIFO overflow
//    assertion, done after 8th handshake.
//  3 pixel_ready low 20 cycles after 2nd pixel -> rom_addr freezes within FIFO_DEPTH(4) words,
//    pixel_valid stays high with pixel 2 stable; release -> remaining pixels in order, no gap.
//  4 start pulsed during RUN and DRAIN -> ignored; exactly one frame, one done pulse.
//  5 reset asserted at 5th pixel -> all outputs to reset values before next edge; new start -> full
//    frame from address 0 with no stale pixels.
//  6 STREAMER_TRANSPARENCY_EN, ROM addr 2 = 16'hF81F -> 7 pixels emitted, (2,0) absent, done pulses.

Source files
------------

// File: rtl/rom_stream_pkg.sv
// Shared definitions for the ROM pixel streamer: FSM state encoding,
// a width helper and the output FIFO depth derivation.
package rom_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Slots beyond the ROM latency: one for the word being presented and
    // one so a stalled consumer does not immediately stop address issue.
    localparam int FIFO_MARGIN = 2;

    // Ceiling log2, never below 1 so a 1-wide dimension still gets a bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        if (result < 1) result = 1;
        return result;
    endfunction

    function automatic int fifo_depth(input int rom_latency);
        return rom_latency + FIFO_MARGIN;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO holding {x, y, colour} entries for the streamer.
// Head word is visible on o_data whenever o_empty is low; a push into an
// empty FIFO becomes visible on the following cycle.
module stream_fifo
    import rom_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_empty,
    output logic [clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PW-1:0]    w_wr_next;
    logic [PW-1:0]    w_rd_next;

    assign o_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer wrap for depths that are not a power of two.
    always_comb begin
        w_wr_next = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
        w_rd_next = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
    end

    // Storage write; contents need no reset because r_count gates validity.
    always_ff @(posedge i_clock) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= w_wr_next;
            if (w_do_pop)  r_rd_ptr <= w_rd_next;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/rom_pixel_streamer.sv
// Walks a WIDTH x HEIGHT row-major image in ROM, one address per cycle,
// tracks each read through a ROM_LATENCY-deep valid pipe and queues the
// returned colours with their coordinates for a valid/ready consumer.
// Address issue is credit-limited so the output FIFO can never overflow.
// Optional build macro: STREAMER_TRANSPARENCY_EN drops words equal to
// TRANSPARENT before they reach the FIFO.
module rom_pixel_streamer
    import rom_stream_pkg::*;
#(
    parameter int                    WIDTH       = 16,
    parameter int                    HEIGHT      = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    BASE_ADDR   = 0,
    parameter int                    ROM_LATENCY = 2,
    parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 16'hF81F
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_start,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ADDR_WIDTH-1:0]      o_rom_addr,
    input  logic [DATA_WIDTH-1:0]      i_rom_data,
    output logic [clog2(WIDTH)-1:0]    o_pixel_x,
    output logic [clog2(HEIGHT)-1:0]   o_pixel_y,
    output logic [DATA_WIDTH-1:0]      o_pixel_data,
    output logic                       o_pixel_valid,
    input  logic                       i_pixel_ready
);

    localparam int XW         = clog2(WIDTH);
    localparam int YW         = clog2(HEIGHT);
    localparam int FIFO_DEPTH = fifo_depth(ROM_LATENCY);
    localparam int CW         = clog2(FIFO_DEPTH + 1);
    localparam int FW         = XW + YW + DATA_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [XW-1:0]         X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]         Y_LAST = YW'(HEIGHT - 1);

`ifdef STREAMER_TRANSPARENCY_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    state_t                           r_state;
    state_t                           w_state_next;
    logic [XW-1:0]                    r_x;
    logic [YW-1:0]                    r_y;
    logic [ADDR_WIDTH-1:0]            r_addr;
    logic [ROM_LATENCY-1:0]           r_pipe_v;
    logic [ROM_LATENCY-1:0][XW-1:0]   r_pipe_x;
    logic [ROM_LATENCY-1:0][YW-1:0]   r_pipe_y;

    logic [CW-1:0]          w_fifo_count;
    logic [CW-1:0]          w_in_flight;
    logic                   w_fifo_empty;
    logic [FW-1:0]          w_fifo_data;
    logic [XW-1:0]          w_head_x;
    logic [YW-1:0]          w_head_y;
    logic [DATA_WIDTH-1:0]  w_head_data;
    logic                   w_credit;
    logic                   w_issue;
    logic                   w_last;
    logic                   w_word_match;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_pipe_empty;

    // Every outstanding read (in the pipe or in the FIFO) holds one FIFO slot.
    assign w_in_flight  = CW'($countones(r_pipe_v));
    assign w_credit     = (int'(w_fifo_count) + int'(w_in_flight)) < FIFO_DEPTH;
    assign w_issue      = (r_state == ST_RUN) && w_credit;
    assign w_last       = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_pipe_empty = (r_pipe_v == '0);
    assign w_word_match = (i_rom_data == TRANSPARENT);
    assign w_push       = r_pipe_v[ROM_LATENCY-1] && !(SKIP_EN && w_word_match);
    assign o_rom_addr   = r_addr;

    // Running x/y/address counters; the address is never multiplied out.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= BASE;
        end else if (r_state == ST_IDLE && i_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= BASE;
        end else if (w_issue) begin
            if (w_last) begin
                r_x    <= '0;
                r_y    <= '0;
                r_addr <= BASE;
            end else begin
                r_addr <= r_addr + 1'b1;
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROM_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                // Stage 0 tags the address issued this cycle with its coordinates.
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) begin
                        r_pipe_v[gi] <= 1'b0;
                        r_pipe_x[gi] <= '0;
                        r_pipe_y[gi] <= '0;
                    end else begin
                        r_pipe_v[gi] <= w_issue;
                        r_pipe_x[gi] <= r_x;
                        r_pipe_y[gi] <= r_y;
                    end
                end
            end else begin : g_body
                // Later stages shift the tag along until the ROM word arrives.
                always_ff @(posedge i_clock or posedge i_reset) begin
                    if (i_reset) begin
                        r_pipe_v[gi] <= 1'b0;
                        r_pipe_x[gi] <= '0;
                        r_pipe_y[gi] <= '0;
                    end else begin
                        r_pipe_v[gi] <= r_pipe_v[gi-1];
                        r_pipe_x[gi] <= r_pipe_x[gi-1];
                        r_pipe_y[gi] <= r_pipe_y[gi-1];
                    end
                end
            end
        end
    endgenerate

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_data  ({r_pipe_x[ROM_LATENCY-1], r_pipe_y[ROM_LATENCY-1], i_rom_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign {w_head_x, w_head_y, w_head_data} = w_fifo_data;
    assign o_pixel_valid = !w_fifo_empty;
    assign w_pop         = o_pixel_valid && i_pixel_ready;
    // Pixel fields read zero while nothing is being presented.
    assign o_pixel_x     = o_pixel_valid ? w_head_x    : '0;
    assign o_pixel_y     = o_pixel_valid ? w_head_y    : '0;
    assign o_pixel_data  = o_pixel_valid ? w_head_data : '0;

    // Frame state register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next-state and status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                o_busy = 1'b1;
                if (w_issue && w_last) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (w_fifo_empty && w_pipe_empty) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

endmodule
